// File: rtl/data_memory_pkg.sv
// Purpose: shared types and helpers for the data memory arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package data_memory_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_id_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Word 0 is reserved and read-only: stores there are refused like
    // out-of-range accesses.
    function automatic logic access_faults(
        input logic [DATA_WIDTH-1:0] addr,
        input logic                  is_write,
        input logic [DATA_WIDTH-1:0] depth
    );
        return (addr >= depth) || (is_write && (addr == '0));
    endfunction

endpackage

// File: rtl/data_memory_arbiter.sv
// Purpose: arbitrates core and dma requests onto one single-port data memory, core priority with dma starvation guard.
// Latency: request accepted in cycle N, response valid in cycle N+1 from a one-entry registered slot.
// Backpressure: a full slot whose owner is not ready blocks both requesters; drain and refill can share a cycle.
// Ports: core_req_* / dma_req_* valid-ready request ports, core_resp_* / dma_resp_* response handshakes,
//        resp_read_data / resp_error shared response payload, mem_* drive and sample the memory.
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_write,
    input  logic [DATA_WIDTH-1:0] core_req_address,
    input  logic [DATA_WIDTH-1:0] core_req_write_data,

    input  logic                  dma_req_valid,
    output logic                  dma_req_ready,
    input  logic                  dma_req_write,
    input  logic [DATA_WIDTH-1:0] dma_req_address,
    input  logic [DATA_WIDTH-1:0] dma_req_write_data,

    output logic                  core_resp_valid,
    input  logic                  core_resp_ready,
    output logic                  dma_resp_valid,
    input  logic                  dma_resp_ready,
    output logic [DATA_WIDTH-1:0] resp_read_data,
    output logic                  resp_error,

    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int                    WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [DATA_WIDTH-1:0] DEPTH_W  = DATA_WIDTH'(DEPTH);

    slot_state_t           r_slot_state;
    port_id_t              r_owner;
    logic [WAIT_W-1:0]     r_wait_count;
    logic [DATA_WIDTH-1:0] r_resp_read_data;
    logic                  r_resp_error;

    logic                  w_owner_ready;
    logic                  w_can_accept;
    logic                  w_dma_forced;
    logic                  w_grant_core;
    logic                  w_grant_dma;
    logic                  w_accept;
    port_id_t              w_winner;
    logic                  w_sel_write;
    logic [DATA_WIDTH-1:0] w_sel_address;
    logic [DATA_WIDTH-1:0] w_sel_write_data;
    logic                  w_fault;
    logic                  w_mem_go;

    // Gating with reset keeps ready and memory strobes low while reset is held,
    // so nothing reaches memory once reset asserts mid-transaction.
    assign w_owner_ready = (r_owner == PORT_DMA) ? dma_resp_ready : core_resp_ready;
    assign w_can_accept  = reset && ((r_slot_state == SLOT_EMPTY) || w_owner_ready);

    assign w_dma_forced = dma_req_valid && (r_wait_count == WAIT_MAX);
    assign w_grant_dma  = w_can_accept && dma_req_valid && (w_dma_forced || !core_req_valid);
    assign w_grant_core = w_can_accept && core_req_valid && !w_dma_forced;
    assign w_accept     = w_grant_core || w_grant_dma;
    assign w_winner     = w_grant_dma ? PORT_DMA : PORT_CORE;

    assign w_sel_write      = (w_winner == PORT_DMA) ? dma_req_write      : core_req_write;
    assign w_sel_address    = (w_winner == PORT_DMA) ? dma_req_address    : core_req_address;
    assign w_sel_write_data = (w_winner == PORT_DMA) ? dma_req_write_data : core_req_write_data;

    assign w_fault  = access_faults(w_sel_address, w_sel_write, DEPTH_W);
    assign w_mem_go = w_accept && !w_fault;

    assign core_req_ready = w_grant_core;
    assign dma_req_ready  = w_grant_dma;

    // Faulting accesses leave the whole memory bus idle, not just the enables.
    assign mem_address      = w_mem_go ? w_sel_address : '0;
    assign mem_write_data   = (w_mem_go && w_sel_write) ? w_sel_write_data : '0;
    assign mem_write_enable = w_mem_go && w_sel_write;
    assign mem_read_enable  = w_mem_go && !w_sel_write;

    assign core_resp_valid = (r_slot_state == SLOT_FULL) && (r_owner == PORT_CORE);
    assign dma_resp_valid  = (r_slot_state == SLOT_FULL) && (r_owner == PORT_DMA);
    assign resp_read_data  = r_resp_read_data;
    assign resp_error      = r_resp_error;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot_state     <= SLOT_EMPTY;
            r_owner          <= PORT_CORE;
            r_resp_read_data <= '0;
            r_resp_error     <= 1'b0;
        end else if (w_accept) begin
            r_slot_state     <= SLOT_FULL;
            r_owner          <= w_winner;
            r_resp_read_data <= (w_fault || w_sel_write) ? '0 : mem_read_data;
            r_resp_error     <= w_fault;
        end else if ((r_slot_state == SLOT_FULL) && w_owner_ready) begin
            r_slot_state <= SLOT_EMPTY;
        end
    end

    // Counts consecutive denied dma cycles, including cycles lost to a blocked
    // slot; a dropped request forfeits its accumulated priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_count <= '0;
        end else if (!dma_req_valid || w_grant_dma) begin
            r_wait_count <= '0;
        end else if (r_wait_count != WAIT_MAX) begin
            r_wait_count <= r_wait_count + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    localparam int DEPTH    = 32;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req_valid, core_req_ready, core_req_write;
    logic [31:0] core_req_address, core_req_write_data;
    logic        dma_req_valid, dma_req_ready, dma_req_write;
    logic [31:0] dma_req_address, dma_req_write_data;
    logic        core_resp_valid, core_resp_ready, dma_resp_valid, dma_resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;

    logic [31:0] tb_mem  [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: slot occupancy, owner (0 core, 1 dma), dma denial count.
    bit          m_full  = 0;
    int          m_owner = 0;
    int          m_wait  = 0;
    logic [31:0] m_data  = '0;
    logic        m_err   = 1'b0;

    data_memory_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock               (clock),
        .reset               (reset),
        .core_req_valid      (core_req_valid),
        .core_req_ready      (core_req_ready),
        .core_req_write      (core_req_write),
        .core_req_address    (core_req_address),
        .core_req_write_data (core_req_write_data),
        .dma_req_valid       (dma_req_valid),
        .dma_req_ready       (dma_req_ready),
        .dma_req_write       (dma_req_write),
        .dma_req_address     (dma_req_address),
        .dma_req_write_data  (dma_req_write_data),
        .core_resp_valid     (core_resp_valid),
        .core_resp_ready     (core_resp_ready),
        .dma_resp_valid      (dma_resp_valid),
        .dma_resp_ready      (dma_resp_ready),
        .resp_read_data      (resp_read_data),
        .resp_error          (resp_error),
        .mem_address         (mem_address),
        .mem_write_data      (mem_write_data),
        .mem_write_enable    (mem_write_enable),
        .mem_read_enable     (mem_read_enable),
        .mem_read_data       (mem_read_data)
    );

    always #5 clock = ~clock;

    // Memory behind the arbiter: combinational read, write on the rising edge.
    assign mem_read_data = (mem_address < 32'(DEPTH)) ? tb_mem[mem_address[4:0]] : 32'hBAD0_BAD0;
    always @(posedge clock) begin
        if (mem_write_enable) tb_mem[mem_address[4:0]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dv, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic crr, input logic drr);
        core_req_valid = cv; core_req_write = cw; core_req_address = ca; core_req_write_data = cd;
        dma_req_valid  = dv; dma_req_write  = dw; dma_req_address  = da; dma_req_write_data  = dd;
        core_resp_ready = crr; dma_resp_ready = drr;
    endtask

    // Called just after a falling edge with inputs already driven: checks every
    // output against the reference, advances the reference across the rising
    // edge and returns at the next falling edge.
    task automatic cycle();
        logic        owner_rdy, can, bad, go, wr;
        logic [31:0] addr, wd;
        int          win;
        #1;
        if (!reset) begin
            m_full = 0;
            m_wait = 0;
        end
        owner_rdy = (m_owner == 1) ? dma_resp_ready : core_resp_ready;
        can = reset && (!m_full || owner_rdy);
        win = 0;
        if (can) begin
            if (dma_req_valid && m_wait == MAX_WAIT) win = 2;
            else if (core_req_valid)                 win = 1;
            else if (dma_req_valid)                  win = 2;
        end
        addr = (win == 2) ? dma_req_address    : core_req_address;
        wd   = (win == 2) ? dma_req_write_data : core_req_write_data;
        wr   = (win == 2) ? dma_req_write      : core_req_write;
        bad  = (addr >= 32'(DEPTH)) || (wr && addr == 0);
        go   = (win != 0) && !bad;

        check("core_req_ready",   core_req_ready,   win == 1);
        check("dma_req_ready",    dma_req_ready,    win == 2);
        check("mem_read_enable",  mem_read_enable,  go && !wr);
        check("mem_write_enable", mem_write_enable, go && wr);
        check("mem_address",      mem_address,      go ? addr : 32'd0);
        check("mem_write_data",   mem_write_data,   (go && wr) ? wd : 32'd0);
        check("core_resp_valid",  core_resp_valid,  m_full && m_owner == 0);
        check("dma_resp_valid",   dma_resp_valid,   m_full && m_owner == 1);
        if (m_full) begin
            check("resp_read_data", resp_read_data, m_data);
            check("resp_error",     resp_error,     m_err);
        end

        if (reset) begin
            if (win != 0) begin
                m_full  = 1;
                m_owner = win - 1;
                m_err   = bad;
                if (bad) m_data = 0;
                else if (wr) begin
                    ref_mem[addr[4:0]] = wd;
                    m_data = 0;
                end else m_data = ref_mem[addr[4:0]];
            end else if (m_full && owner_rdy) begin
                m_full = 0;
            end
            if (!dma_req_valid || win == 2) m_wait = 0;
            else if (m_wait < MAX_WAIT)     m_wait++;
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[5]  = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;

        // Reset state, with requests present to show ready is held low.
        reset = 1'b0;
        drive(1, 0, 5, 0, 1, 0, 6, 0, 1, 1);
        @(negedge clock);
        cycle();
        check("reset_read_data", resp_read_data, 32'd0);
        check("reset_error",     resp_error,     32'd0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();

        // Core load of word 5.
        drive(1, 0, 5, 0, 0, 0, 0, 0, 1, 1);
        #1 check("load_ready", core_req_ready, 1);
        cycle();
        check("load_resp_valid", core_resp_valid, 1);
        check("load_data",       resp_read_data,  32'hDEAD_BEEF);
        check("load_error",      resp_error,      0);

        // Owner stalls for 3 cycles: both requesters blocked, response stable.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 9, 0, 1, 0, 10, 0, 0, 1);
            #1 check("stall_core_ready", core_req_ready, 0);
            check("stall_dma_ready", dma_req_ready, 0);
            check("stall_data", resp_read_data, 32'hDEAD_BEEF);
            cycle();
        end
        drive(1, 0, 9, 0, 1, 0, 10, 0, 1, 1);
        #1 check("refill_core_ready", core_req_ready, 1);
        cycle();

        // Starvation guard: from a cleared counter, core 4 grants then dma 1.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, $urandom_range(0, 31), 0, 1, 0, $urandom_range(0, 31), 0, 1, 1);
            #1 check("starve_core_grant", core_req_ready, (i % 5) != 4);
            check("starve_dma_grant", dma_req_ready, (i % 5) == 4);
            cycle();
        end

        // Faulting dma stores: out of range, then to word 0.
        drive(0, 0, 0, 0, 1, 1, 40, 32'h1111_2222, 1, 1);
        #1 check("oor_no_write", mem_write_enable, 0);
        cycle();
        check("oor_resp_valid", dma_resp_valid, 1);
        check("oor_error",      resp_error,     1);
        check("oor_data",       resp_read_data, 0);
        drive(0, 0, 0, 0, 1, 1, 0, 32'h3333_4444, 1, 1);
        #1 check("zero_no_write", mem_write_enable, 0);
        cycle();
        check("zero_error", resp_error, 1);
        check("zero_data",  resp_read_data, 0);

        // Reset while the slot is full and a dma store is pending.
        drive(1, 1, 7, 32'h1234_5678, 0, 0, 0, 0, 1, 1);
        cycle();
        drive(0, 0, 0, 0, 1, 1, 8, 32'hCAFE_F00D, 0, 1);
        cycle();
        reset = 1'b0;
        #1 check("rst_resp_valid", core_resp_valid, 0);
        check("rst_no_write", mem_write_enable, 0);
        check("rst_dma_ready", dma_req_ready, 0);
        cycle();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        check("rst_store_kept", tb_mem[7], 32'h1234_5678);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 39), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 39), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            cycle();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();

        for (int i = 0; i < DEPTH; i++) check("mem_word", tb_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
